// File: rtl/hazard_ctrl_unit.sv
// Load-use stall and mispredict flush controller between ID and EX.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int XLEN        = 32,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_EXTRA = 0,
  parameter int CNT_W       = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      rs1_ID,
  input  logic [4:0]      rs2_ID,
  input  logic            rs1_used_ID,
  input  logic            rs2_used_ID,
  input  logic            valid_ID,
  input  logic [XLEN-1:0] pc_ID,
  input  logic [4:0]      rd_EX,
  input  logic            is_load_EX,
  input  logic            ctrl_EX,
  input  logic [XLEN-1:0] target_EX,
  output logic            stall_PC,
  output logic            stall_ID,
  output logic            flush_ID_EX,
  output logic            flush_IF_ID,
  output logic            comp_o,
  output logic            busy_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_o,
  output logic [CNT_W-1:0] perf_mispred_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LSTALL = 2'd1,
    S_FLUSH  = 2'd2
  } state_e;

  localparam logic [2:0] LoadCnt  = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FlushCnt = 3'(FLUSH_EXTRA);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic luse, mispred;
  logic stall_d, flush_id_ex_d, flush_if_id_d, comp_d;

  // Both terms are AND-gated by valid_ID / ctrl_EX so idle inputs never leak X.
  assign luse = is_load_EX & valid_ID & (rd_EX != 5'd0) &
                ((rs1_used_ID & (rs1_ID == rd_EX)) |
                 (rs2_used_ID & (rs2_ID == rd_EX)));
  assign mispred = ctrl_EX & (~valid_ID | (pc_ID != target_EX));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_d       = 1'b0;
    flush_id_ex_d = 1'b0;
    flush_if_id_d = 1'b0;
    comp_d        = 1'b0;
    case (state_q)
      S_IDLE, S_LSTALL: begin
        if (mispred) begin
          comp_d        = 1'b1;
          flush_if_id_d = 1'b1;
          flush_id_ex_d = 1'b1;
          if (FLUSH_EXTRA > 0) begin
            state_d = S_FLUSH;
            cnt_d   = FlushCnt;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end
        end else if (state_q == S_LSTALL) begin
          // The load has already left EX; keep bubbling until the count runs out.
          stall_d       = 1'b1;
          flush_id_ex_d = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else if (luse) begin
          stall_d       = 1'b1;
          flush_id_ex_d = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = S_LSTALL;
            cnt_d   = LoadCnt;
          end
        end
      end
      S_FLUSH: begin
        // ID holds squashed slots here, so load-use is ignored.
        flush_if_id_d = 1'b1;
        if (mispred) begin
          comp_d        = 1'b1;
          flush_id_ex_d = 1'b1;
          cnt_d         = FlushCnt;
        end else if (cnt_q <= 3'd1) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is held, regardless of stale state.
  assign stall_PC    = stall_d & ~rst_i;
  assign stall_ID    = stall_d & ~rst_i;
  assign flush_ID_EX = flush_id_ex_d & ~rst_i;
  assign flush_IF_ID = flush_if_id_d & ~rst_i;
  assign comp_o      = comp_d & ~rst_i;
  assign busy_o      = (state_q != S_IDLE) & ~rst_i;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_mispred_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q   <= '0;
      perf_mispred_q <= '0;
    end else begin
      if (stall_PC && (perf_stall_q != {CNT_W{1'b1}}))
        perf_stall_q <= perf_stall_q + 1'b1;
      if (comp_o && (perf_mispred_q != {CNT_W{1'b1}}))
        perf_mispred_q <= perf_mispred_q + 1'b1;
    end
  end

  assign perf_stall_o   = perf_stall_q;
  assign perf_mispred_o = perf_mispred_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: two instances (LOAD_LAT=1/FLUSH_EXTRA=0 and LOAD_LAT=3/FLUSH_EXTRA=2)
// share one stimulus stream; output vector is {comp, flush_IF_ID, flush_ID_EX, stall_PC, stall_ID, busy}.
module tb_hazard_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_u, rs2_u, valid, is_load, ctrl;
  logic [31:0] pc, tgt;

  logic spc_a, sid_a, idex_a, ifid_a, comp_a, busy_a;
  logic spc_b, sid_b, idex_b, ifid_b, comp_b, busy_b;
  logic [5:0] va, vb;

  int tests = 0;
  int fails = 0;

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0]  ps_a, pm_a;
  logic [15:0] ps_b, pm_b;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.XLEN(32), .LOAD_LAT(1), .FLUSH_EXTRA(0), .CNT_W(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .rs1_ID(rs1), .rs2_ID(rs2), .rs1_used_ID(rs1_u), .rs2_used_ID(rs2_u),
    .valid_ID(valid), .pc_ID(pc), .rd_EX(rd), .is_load_EX(is_load),
    .ctrl_EX(ctrl), .target_EX(tgt),
    .stall_PC(spc_a), .stall_ID(sid_a), .flush_ID_EX(idex_a), .flush_IF_ID(ifid_a),
    .comp_o(comp_a), .busy_o(busy_a)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_o(ps_a), .perf_mispred_o(pm_a)
`endif
  );

  hazard_ctrl_unit #(.XLEN(32), .LOAD_LAT(3), .FLUSH_EXTRA(2), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_i(rst),
    .rs1_ID(rs1), .rs2_ID(rs2), .rs1_used_ID(rs1_u), .rs2_used_ID(rs2_u),
    .valid_ID(valid), .pc_ID(pc), .rd_EX(rd), .is_load_EX(is_load),
    .ctrl_EX(ctrl), .target_EX(tgt),
    .stall_PC(spc_b), .stall_ID(sid_b), .flush_ID_EX(idex_b), .flush_IF_ID(ifid_b),
    .comp_o(comp_b), .busy_o(busy_b)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_o(ps_b), .perf_mispred_o(pm_b)
`endif
  );

  assign va = {comp_a, ifid_a, idex_a, spc_a, sid_a, busy_a};
  assign vb = {comp_b, ifid_b, idex_b, spc_b, sid_b, busy_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check both instances #1 after inputs were applied on the falling edge.
  task automatic step(input string tag, input logic [5:0] ea, input logic [5:0] eb);
    #1;
    chk({tag, "_a"}, {26'd0, va}, {26'd0, ea});
    chk({tag, "_b"}, {26'd0, vb}, {26'd0, eb});
  endtask

  task automatic quiet();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; rs1_u = 1'b0; rs2_u = 1'b0;
    valid = 1'b0; is_load = 1'b0; ctrl = 1'b0; pc = 32'd0; tgt = 32'd0;
  endtask

  task automatic drv_load(input logic [4:0] r_d, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic v);
    quiet();
    is_load = 1'b1; rd = r_d; rs1 = r1; rs1_u = u1; rs2 = r2; rs2_u = u2; valid = v;
  endtask

  task automatic drv_br(input logic [31:0] t, input logic [31:0] p, input logic v);
    quiet();
    ctrl = 1'b1; tgt = t; pc = p; valid = v;
  endtask

  task automatic cyc_quiet(input string tag, input logic [5:0] ea, input logic [5:0] eb);
    @(negedge clk);
    quiet();
    step(tag, ea, eb);
  endtask

  initial begin
    // Reset cycle with a mispredict pattern on the inputs: outputs must stay low.
    rst = 1'b1;
    drv_br(32'h100, 32'h0C4, 1'b1);
    step("rst_cycle", 6'b000000, 6'b000000);
    @(negedge clk); quiet();
    @(negedge clk); rst = 1'b0;
    step("post_rst", 6'b000000, 6'b000000);

    // Load-use on rs1.
    @(negedge clk); drv_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    step("luse1_c1", 6'b001110, 6'b001110);
    cyc_quiet("luse1_c2", 6'b000000, 6'b001111);
    cyc_quiet("luse1_c3", 6'b000000, 6'b001111);
    cyc_quiet("luse1_c4", 6'b000000, 6'b000000);

    // Excluded cases.
    @(negedge clk); drv_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    step("luse_bubble", 6'b000000, 6'b000000);
    @(negedge clk); drv_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    step("luse_x0", 6'b000000, 6'b000000);
    @(negedge clk); drv_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1);
    step("luse_rs2_unused", 6'b000000, 6'b000000);

    // Load-use on rs2.
    @(negedge clk); drv_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1);
    step("luse2_c1", 6'b001110, 6'b001110);
    cyc_quiet("luse2_c2", 6'b000000, 6'b001111);
    cyc_quiet("luse2_c3", 6'b000000, 6'b001111);
    cyc_quiet("luse2_c4", 6'b000000, 6'b000000);

    // Mispredict with flush extension.
    @(negedge clk); drv_br(32'h100, 32'h0C4, 1'b1);
    step("mp_c1", 6'b111000, 6'b111000);
    cyc_quiet("mp_c2", 6'b000000, 6'b010001);
    cyc_quiet("mp_c3", 6'b000000, 6'b010001);
    cyc_quiet("mp_c4", 6'b000000, 6'b000000);

    // Correct prediction, then a bubble in ID which always counts as a mispredict.
    @(negedge clk); drv_br(32'h0C4, 32'h0C4, 1'b1);
    step("mp_match", 6'b000000, 6'b000000);
    @(negedge clk); drv_br(32'h0C4, 32'h0C4, 1'b0);
    step("mp_bubble", 6'b111000, 6'b111000);
    // Load-use during FLUSH is suppressed in u_b; u_a is idle and stalls.
    @(negedge clk); drv_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    step("flush_luse", 6'b001110, 6'b010001);
    // Re-mispredict during FLUSH reloads the count.
    @(negedge clk); drv_br(32'h200, 32'h0C4, 1'b1);
    step("flush_remp", 6'b111000, 6'b111001);
    cyc_quiet("remp_c2", 6'b000000, 6'b010001);
    cyc_quiet("remp_c3", 6'b000000, 6'b010001);
    cyc_quiet("remp_c4", 6'b000000, 6'b000000);

    // Simultaneous load-use and mispredict: mispredict wins, no stall.
    @(negedge clk);
    drv_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    ctrl = 1'b1; tgt = 32'h100; pc = 32'h0C4;
    step("simul", 6'b111000, 6'b111000);
    cyc_quiet("simul_c2", 6'b000000, 6'b010001);
    cyc_quiet("simul_c3", 6'b000000, 6'b010001);
    cyc_quiet("simul_c4", 6'b000000, 6'b000000);

    // Reset in the middle of LSTALL.
    @(negedge clk); drv_load(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    step("rls_c1", 6'b001110, 6'b001110);
    @(negedge clk); quiet(); rst = 1'b1;
    step("rls_rst", 6'b000000, 6'b000000);
    @(negedge clk); rst = 1'b0;
    step("rls_after", 6'b000000, 6'b000000);

    // Reset in the middle of FLUSH.
    @(negedge clk); drv_br(32'h300, 32'h0C4, 1'b1);
    step("rfl_c1", 6'b111000, 6'b111000);
    @(negedge clk); quiet(); rst = 1'b1;
    step("rfl_rst", 6'b000000, 6'b000000);
    @(negedge clk); rst = 1'b0;
    step("rfl_after", 6'b000000, 6'b000000);

`ifdef HAZARD_PERF_CNT_EN
    // 20 stall cycles on u_a saturate a 4-bit counter; then 3 mispredicts.
    @(negedge clk); quiet(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("perf_clr_stall", {28'd0, ps_a}, 32'd0);
    chk("perf_clr_mp", {28'd0, pm_a}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drv_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1);
    end
    @(negedge clk); quiet();
    #1;
    chk("perf_stall_sat", {28'd0, ps_a}, 32'd15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drv_br(32'h400 + 32'(i * 4), 32'h0C4, 1'b1);
    end
    @(negedge clk); quiet();
    #1;
    chk("perf_mispred", {28'd0, pm_a}, 32'd3);
    chk("perf_stall_hold", {28'd0, ps_a}, 32'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
